// File: rtl/gf163_result_collector.sv
// gf163_result_collector: reassembles the MSB-first 32-bit digit stream of the
// GF(2^163) systolic multiplier into 163-bit words. Completed words go into a
// small valid/ready FIFO. The module flags framing errors and FIFO overflow.
// Optional build macro GF163_PAD_CHECK_EN adds a sticky pad_err output. It is
// raised when a completed frame carries nonzero padding bits [191:163].
module gf163_result_collector #(
  parameter int DIGITS     = 32,
  parameter int FIELD_M    = 163,
  parameter int NUM_DIGITS = 6,
  parameter int DEPTH      = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               ctro_in,
  input  logic [DIGITS-1:0]  po_in,
  output logic [FIELD_M-1:0] res_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               busy,
  output logic               ovf,
  output logic               frame_err,
  input  logic               err_clr
`ifdef GF163_PAD_CHECK_EN
  ,
  output logic               pad_err
`endif
);

  localparam int SR_W  = DIGITS * NUM_DIGITS;
  localparam int CNT_W = $clog2(NUM_DIGITS);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                     state_reg;
  logic [CNT_W-1:0]           cnt_reg;
  // Only the previous NUM_DIGITS-1 digits are kept.
  // The current digit completes the frame straight from po_in.
  logic [SR_W-DIGITS-1:0]     sr_reg;
  logic [SR_W-1:0]            assembled;

  logic [FIELD_M-1:0]         mem [DEPTH];
  logic [PTR_W:0]             wr_ptr_reg;
  logic [PTR_W:0]             rd_ptr_reg;

  logic empty, full, pop, push, write_en, drop, fe_set;

  assign assembled = {sr_reg, po_in};
  assign busy      = (state_reg == COLLECT);

  // A frame completes on its last digit, unless a new frame start preempts it.
  assign push   = (state_reg == COLLECT) && !ctro_in && (cnt_reg == CNT_W'(NUM_DIGITS - 1));
  assign fe_set = (state_reg == COLLECT) && ctro_in;

  // The extra pointer MSB separates full (MSBs differ) from empty (all equal).
  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg == (rd_ptr_reg ^ {1'b1, {PTR_W{1'b0}}}));
  assign res_valid = !empty;
  assign res_out   = mem[rd_ptr_reg[PTR_W-1:0]];
  assign pop       = res_valid && res_ready;
  // When full, a simultaneous pop frees the slot that is written this cycle.
  assign write_en  = push && (!full || pop);
  assign drop      = push && full && !pop;

  // Frame collection FSM: counts digits and shifts them into the assembly register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      sr_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ctro_in) begin
            sr_reg    <= {sr_reg[SR_W-2*DIGITS-1:0], po_in};
            cnt_reg   <= CNT_W'(1);
            state_reg <= COLLECT;
          end
        end
        COLLECT: begin
          sr_reg <= {sr_reg[SR_W-2*DIGITS-1:0], po_in};
          if (ctro_in) begin
            // Restart on the new frame's first digit.
            // Stale digits age out of the register before the next push.
            cnt_reg <= CNT_W'(1);
          end else if (cnt_reg == CNT_W'(NUM_DIGITS - 1)) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // Output FIFO storage and pointers. There is no bypass, so a push shows up one cycle later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (write_en) begin
        mem[wr_ptr_reg[PTR_W-1:0]] <= assembled[FIELD_M-1:0];
        wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
    end
  end

`ifdef GF163_PAD_CHECK_EN
  logic pad_set;
  assign pad_set = push && (|assembled[SR_W-1:FIELD_M]);

  // Sticky pad flag. A set event in the same cycle beats err_clr.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pad_err <= 1'b0;
    else       pad_err <= pad_set | (pad_err & ~err_clr);
  end
`else
  // Padding bits are deliberately discarded in this build.
  logic pad_unused;
  assign pad_unused = ^assembled[SR_W-1:FIELD_M];
`endif

  // Sticky error flags. A set event in the same cycle beats err_clr.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ovf       <= drop   | (ovf & ~err_clr);
      frame_err <= fe_set | (frame_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_gf163_result_collector.sv
// Self-checking bench for gf163_result_collector.
// It runs directed scenarios plus randomized traffic.
// A frame/queue-level reference model in the bench predicts every output.
module tb_gf163_result_collector;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rstn;
  logic         ctro_in;
  logic [31:0]  po_in;
  logic [162:0] res_out;
  logic         res_valid;
  logic         res_ready;
  logic         busy;
  logic         ovf;
  logic         frame_err;
  logic         err_clr;
`ifdef GF163_PAD_CHECK_EN
  logic         pad_err;
`endif

  gf163_result_collector #(.DIGITS(32), .FIELD_M(163), .NUM_DIGITS(6), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .ctro_in(ctro_in), .po_in(po_in),
    .res_out(res_out), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .ovf(ovf), .frame_err(frame_err), .err_clr(err_clr)
`ifdef GF163_PAD_CHECK_EN
    , .pad_err(pad_err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the digits of the open frame, plus a queue of stored words.
  logic [162:0] exp_q[$];
  bit           m_busy;
  int           m_n;
  logic [31:0]  m_digs[6];
  bit           m_ovf, m_fe, m_pad;

  logic [31:0]  fr[6];   // frame under construction in directed tests

  function automatic logic [191:0] join_model();
    logic [191:0] w = '0;
    for (int i = 0; i < 6; i++) w = (w << 32) | 192'(m_digs[i]);
    return w;
  endfunction

  function automatic logic [162:0] fr_word();
    logic [191:0] w = '0;
    for (int i = 0; i < 6; i++) w = (w << 32) | 192'(fr[i]);
    return w[162:0];
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_busy = 0; m_n = 0; m_ovf = 0; m_fe = 0; m_pad = 0;
  endtask

  // Drive one cycle's inputs from a negedge, advance the model, and return at the next negedge.
  task automatic step(input bit c, input logic [31:0] p, input bit rdy, input bit clr);
    int sz;
    bit pop, done, fe_set, ovf_set, pad_set;
    logic [191:0] w;
    ctro_in = c; po_in = p; res_ready = rdy; err_clr = clr;
    sz = exp_q.size();
    pop = (sz > 0) && rdy;
    done = 0; fe_set = 0; ovf_set = 0; pad_set = 0;
    if (c) begin
      if (m_busy) fe_set = 1;
      m_busy = 1; m_n = 0;
    end
    if (m_busy) begin
      m_digs[m_n] = p;
      m_n++;
      if (m_n == 6) begin done = 1; m_busy = 0; m_n = 0; end
    end
    if (pop) void'(exp_q.pop_front());
    if (done) begin
      w = join_model();
      pad_set = (w[191:163] != 0);
      if (sz == DEPTH && !pop) ovf_set = 1;
      else exp_q.push_back(w[162:0]);
    end
    m_ovf = ovf_set || (m_ovf && !clr);
    m_fe  = fe_set  || (m_fe  && !clr);
    m_pad = pad_set || (m_pad && !clr);
    @(negedge clk);
  endtask

  task automatic send_frame(input bit rdy);
    for (int i = 0; i < 6; i++) step(i == 0, fr[i], rdy, 1'b0);
  endtask

  task automatic do_reset();
    rstn = 1'b0; ctro_in = 0; po_in = '0; res_ready = 0; err_clr = 0;
    model_clear();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", res_valid); end
    n_checks++; if (res_out !== '0) begin n_fail++; $display("FAIL reset_res_out: got %h expected 0", res_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if ({ovf, frame_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {ovf, frame_err}); end
    $display("reset: valid=%b busy=%b ovf=%b frame_err=%b", res_valid, busy, ovf, frame_err);
  endtask

  task automatic test_single_frame();
    do_reset();
    fr[0] = 32'h7;
    for (int i = 1; i < 6; i++) fr[i] = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      step(i == 0, fr[i], 1'b1, 1'b0);
      n_checks++;
      if (res_valid !== (i == 5)) begin n_fail++; $display("FAIL single_latency digit %0d: got valid=%b expected %b", i, res_valid, (i == 5)); end
      if (i == 0) begin
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
      end
    end
    n_checks++; if (res_out !== {163{1'b1}}) begin n_fail++; $display("FAIL single_word: got %h expected all ones", res_out); end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle: got valid=%b expected 0", res_valid); end
    $display("single frame: word=%h", {163{1'b1}});
  endtask

  task automatic test_back_to_back();
    logic [162:0] w_c;
    do_reset();
    fr = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1};
    send_frame(1'b0);
    fr = '{32'h4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    send_frame(1'b0);
    n_checks++; if (res_out !== 163'd1) begin n_fail++; $display("FAIL b2b_first: got %h expected 1", res_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b expected 0", busy); end
    // Third frame pops on its last digit. The FIFO is full, so push and pop both happen.
    for (int i = 0; i < 6; i++) fr[i] = $urandom;
    fr[0] = fr[0] & 32'h7;
    w_c = fr_word();
    for (int i = 0; i < 6; i++) step(i == 0, fr[i], i == 5, 1'b0);
    n_checks++; if (res_out !== (163'd1 << 162)) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", res_out, 163'd1 << 162); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b expected 0", ovf); end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    n_checks++; if (res_out !== w_c || res_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_third: got %h/%b expected %h/1", res_out, res_valid, w_c); end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b expected 0", res_valid); end
    $display("back-to-back: three words drained");
  endtask

  task automatic test_overflow();
    logic [162:0] w1, w2;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 6; i++) fr[i] = $urandom;
      if (f == 0) w1 = fr_word();
      if (f == 1) w2 = fr_word();
      send_frame(1'b0);
    end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", ovf); end
    n_checks++; if (res_out !== w1) begin n_fail++; $display("FAIL ovf_head1: got %h expected %h", res_out, w1); end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    n_checks++; if (res_out !== w2) begin n_fail++; $display("FAIL ovf_head2: got %h expected %h", res_out, w2); end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_third_lost: got valid=%b expected 0", res_valid); end
    step(1'b0, 32'h0, 1'b0, 1'b1);
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", ovf); end
    $display("overflow: third frame dropped");
  endtask

  task automatic test_frame_err();
    logic [162:0] w;
    do_reset();
    step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b0, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) fr[i] = $urandom;
    w = fr_word();
    send_frame(1'b0);
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL fe_set: got %b expected 1", frame_err); end
    n_checks++; if (res_valid !== 1'b1 || res_out !== w) begin n_fail++; $display("FAIL fe_word: got %h/%b expected %h/1", res_out, res_valid, w); end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL fe_one_word: got valid=%b expected 0", res_valid); end
    step(1'b0, 32'h0, 1'b0, 1'b1);
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL fe_clear: got %b expected 0", frame_err); end
    $display("frame error: word=%h", w);
  endtask

  task automatic test_reset_mid();
    logic [162:0] w;
    do_reset();
    for (int i = 0; i < 6; i++) fr[i] = $urandom;
    send_frame(1'b0);
    for (int i = 0; i < 4; i++) step(i == 0, $urandom, 1'b0, 1'b0);
    #2 rstn = 1'b0; ctro_in = 0;
    model_clear();
    #1;
    n_checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got valid=%b busy=%b expected 0/0", res_valid, busy); end
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) fr[i] = $urandom;
    w = fr_word();
    send_frame(1'b1);
    n_checks++; if (res_valid !== 1'b1 || res_out !== w) begin n_fail++; $display("FAIL mid_reset_new: got %h/%b expected %h/1", res_out, res_valid, w); end
    $display("reset mid-frame: new word=%h", w);
  endtask

`ifdef GF163_PAD_CHECK_EN
  task automatic test_pad();
    do_reset();
    fr = '{32'h8000_0001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    send_frame(1'b0);
    n_checks++; if (pad_err !== 1'b1) begin n_fail++; $display("FAIL pad_set: got %b expected 1", pad_err); end
    n_checks++; if (res_out !== (163'd1 << 160)) begin n_fail++; $display("FAIL pad_word: got %h expected %h", res_out, 163'd1 << 160); end
    step(1'b0, 32'h0, 1'b1, 1'b1);
    n_checks++; if (pad_err !== 1'b0) begin n_fail++; $display("FAIL pad_clear: got %b expected 0", pad_err); end
    $display("pad check: pad_err raised and cleared");
  endtask
`endif

  task automatic test_random();
    bit c, rdy, clr;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      c   = m_busy ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 19) == 0);
      if (rdy && res_valid) $display("pop word=%h", res_out);
      step(c, $urandom, rdy, clr);
      n_checks++;
      if (res_valid !== (exp_q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid cyc %0d: got %b expected %b", cyc, res_valid, exp_q.size() > 0); end
      if (exp_q.size() > 0) begin
        n_checks++;
        if (res_out !== exp_q[0]) begin n_fail++; $display("FAIL rnd_word cyc %0d: got %h expected %h", cyc, res_out, exp_q[0]); end
      end
      n_checks++;
      if ({busy, ovf, frame_err} !== {m_busy, m_ovf, m_fe}) begin
        n_fail++; $display("FAIL rnd_status cyc %0d: got busy/ovf/fe=%b expected %b", cyc, {busy, ovf, frame_err}, {m_busy, m_ovf, m_fe});
      end
`ifdef GF163_PAD_CHECK_EN
      n_checks++;
      if (pad_err !== m_pad) begin n_fail++; $display("FAIL rnd_pad cyc %0d: got %b expected %b", cyc, pad_err, m_pad); end
`endif
    end
  endtask

  initial begin
    rstn = 1'b0; ctro_in = 0; po_in = '0; res_ready = 0; err_clr = 0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_frame_err();
    test_reset_mid();
`ifdef GF163_PAD_CHECK_EN
    test_pad();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
